// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one external combinational ALU between two requesters.
// Round-robin arbitration in IDLE. Operands are registered before they drive the
// ALU, and the ALU result is registered before it is returned. Only one operation
// is in flight at a time, and its response goes to the requester that issued it.
//
// Ports:
//   clk, rst_n            clock and asynchronous active-low reset
//   rN_valid/rN_ready     request handshake for requester N (N = 0, 1)
//   rN_dataa/datab/ctr    request operands and ALU control code
//   rN_rsp_valid/ready    response handshake for requester N
//   rN_rsp_result/less/zero  registered ALU outputs (zero on the non-owner port)
//   alu_dataa/datab/ctr   to the ALU, driven from the operand registers
//   alu_result/less/zero  from the ALU
//   busy                  high whenever an operation is in flight
module alu_arbiter #(
  parameter int DATA_W = 32,
  parameter int CTR_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              r0_valid,
  output logic              r0_ready,
  input  logic [DATA_W-1:0] r0_dataa,
  input  logic [DATA_W-1:0] r0_datab,
  input  logic [CTR_W-1:0]  r0_ctr,
  output logic              r0_rsp_valid,
  input  logic              r0_rsp_ready,
  output logic [DATA_W-1:0] r0_rsp_result,
  output logic              r0_rsp_less,
  output logic              r0_rsp_zero,
  input  logic              r1_valid,
  output logic              r1_ready,
  input  logic [DATA_W-1:0] r1_dataa,
  input  logic [DATA_W-1:0] r1_datab,
  input  logic [CTR_W-1:0]  r1_ctr,
  output logic              r1_rsp_valid,
  input  logic              r1_rsp_ready,
  output logic [DATA_W-1:0] r1_rsp_result,
  output logic              r1_rsp_less,
  output logic              r1_rsp_zero,
  output logic [DATA_W-1:0] alu_dataa,
  output logic [DATA_W-1:0] alu_datab,
  output logic [CTR_W-1:0]  alu_ctr,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_less,
  input  logic              alu_zero,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  state_t            state, state_nxt;
  logic              last_grant;
  logic              owner;
  logic              grant;
  logic              accept;
  logic              owner_rsp_ready;
  logic [DATA_W-1:0] op_a, op_b;
  logic [CTR_W-1:0]  op_ctr;
  logic [DATA_W-1:0] rsp_result;
  logic              rsp_less, rsp_zero;

  // Tie goes to the requester not served last; otherwise whoever is valid.
  always_comb begin
    if (r0_valid && r1_valid) grant = ~last_grant;
    else                      grant = r1_valid;
  end

  assign owner_rsp_ready = owner ? r1_rsp_ready : r0_rsp_ready;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = ISSUE;
      ISSUE:   state_nxt = RESP;
      RESP:    if (owner_rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic. Ready is also gated by rst_n so that handshakes are
  // suppressed while reset is held, even when a requester is valid.
  always_comb begin
    r0_ready      = rst_n && (state == IDLE) && r0_valid && !grant;
    r1_ready      = rst_n && (state == IDLE) && r1_valid &&  grant;
    accept        = r0_ready || r1_ready;
    r0_rsp_valid  = (state == RESP) && !owner;
    r1_rsp_valid  = (state == RESP) &&  owner;
    busy          = (state != IDLE);
    r0_rsp_result = owner ? '0 : rsp_result;
    r0_rsp_less   = !owner && rsp_less;
    r0_rsp_zero   = !owner && rsp_zero;
    r1_rsp_result = owner ? rsp_result : '0;
    r1_rsp_less   = owner && rsp_less;
    r1_rsp_zero   = owner && rsp_zero;
  end

  // Operand, ownership and response registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= 1'b1;
      owner      <= 1'b0;
      op_a       <= '0;
      op_b       <= '0;
      op_ctr     <= '0;
      rsp_result <= '0;
      rsp_less   <= 1'b0;
      rsp_zero   <= 1'b0;
    end else begin
      if (accept) begin
        op_a       <= grant ? r1_dataa : r0_dataa;
        op_b       <= grant ? r1_datab : r0_datab;
        op_ctr     <= grant ? r1_ctr   : r0_ctr;
        owner      <= grant;
        last_grant <= grant;
      end
      if (state == ISSUE) begin
        rsp_result <= alu_result;
        rsp_less   <= alu_less;
        rsp_zero   <= alu_zero;
      end
    end
  end

  assign alu_dataa = op_a;
  assign alu_datab = op_b;
  assign alu_ctr   = op_ctr;

endmodule

// File: tb/tb_alu_arbiter.sv
module tb_alu_arbiter;
  localparam int DATA_W = 32;
  localparam int CTR_W  = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              r0_valid = 1'b0, r1_valid = 1'b0;
  logic              r0_ready, r1_ready;
  logic [31:0]       r0_dataa = '0, r0_datab = '0, r1_dataa = '0, r1_datab = '0;
  logic [3:0]        r0_ctr = '0, r1_ctr = '0;
  logic              r0_rsp_valid, r1_rsp_valid;
  logic              r0_rsp_ready = 1'b1, r1_rsp_ready = 1'b1;
  logic [31:0]       r0_rsp_result, r1_rsp_result;
  logic              r0_rsp_less, r0_rsp_zero, r1_rsp_less, r1_rsp_zero;
  logic [31:0]       alu_dataa, alu_datab, alu_result;
  logic [3:0]        alu_ctr;
  logic              alu_less, alu_zero;
  logic              busy;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model state (transaction level)
  bit          m_busy  = 1'b0;
  bit          m_owner = 1'b0;
  bit          m_last  = 1'b1;
  int          m_age   = 0;
  logic [33:0] m_exp   = '0;
  int          n_rsp_model = 0;
  int          n_rsp_seen  = 0;

  alu_arbiter #(.DATA_W(DATA_W), .CTR_W(CTR_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_dataa(r0_dataa), .r0_datab(r0_datab),
    .r0_ctr(r0_ctr), .r0_rsp_valid(r0_rsp_valid), .r0_rsp_ready(r0_rsp_ready),
    .r0_rsp_result(r0_rsp_result), .r0_rsp_less(r0_rsp_less), .r0_rsp_zero(r0_rsp_zero),
    .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_dataa(r1_dataa), .r1_datab(r1_datab),
    .r1_ctr(r1_ctr), .r1_rsp_valid(r1_rsp_valid), .r1_rsp_ready(r1_rsp_ready),
    .r1_rsp_result(r1_rsp_result), .r1_rsp_less(r1_rsp_less), .r1_rsp_zero(r1_rsp_zero),
    .alu_dataa(alu_dataa), .alu_datab(alu_datab), .alu_ctr(alu_ctr),
    .alu_result(alu_result), .alu_less(alu_less), .alu_zero(alu_zero),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Behavioural ALU stub: {less, zero, result}
  function automatic logic [33:0] alu_f(input logic [31:0] a, input logic [31:0] b,
                                        input logic [3:0] c);
    logic [31:0] r;
    logic        l;
    l = 1'b0;
    case (c)
      4'b0000: r = a + b;
      4'b1000: r = a - b;
      4'b0100: r = a ^ b;
      4'b0110: r = a | b;
      4'b0111: r = a & b;
      4'b0001: r = a << b[4:0];
      4'b0101: r = a >> b[4:0];
      4'b1101: r = $signed(a) >>> b[4:0];
      4'b0010: begin l = ($signed(a) < $signed(b)); r = {31'd0, l}; end
      4'b0011: begin l = (a < b); r = {31'd0, l}; end
      default: r = a ^ ~b;
    endcase
    return {l, (r == 32'd0), r};
  endfunction

  always_comb {alu_less, alu_zero, alu_result} = alu_f(alu_dataa, alu_datab, alu_ctr);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock cycle: compare the DUT against the model at the falling edge,
  // then advance the model across the rising edge. Returns at posedge+1.
  task automatic tick();
    bit g0, g1, v0, v1, hs;
    @(negedge clk);
    g0 = !m_busy && r0_valid && (!r1_valid || m_last);
    g1 = !m_busy && r1_valid && (!r0_valid || !m_last);
    v0 = m_busy && (m_age >= 1) && !m_owner;
    v1 = m_busy && (m_age >= 1) &&  m_owner;
    chk("r0_ready", {31'd0, r0_ready}, {31'd0, g0});
    chk("r1_ready", {31'd0, r1_ready}, {31'd0, g1});
    chk("busy", {31'd0, busy}, {31'd0, m_busy});
    chk("r0_rsp_valid", {31'd0, r0_rsp_valid}, {31'd0, v0});
    chk("r1_rsp_valid", {31'd0, r1_rsp_valid}, {31'd0, v1});
    if (v0 || v1) begin
      chk("rsp_result", m_owner ? r1_rsp_result : r0_rsp_result, m_exp[31:0]);
      chk("rsp_less", {31'd0, m_owner ? r1_rsp_less : r0_rsp_less}, {31'd0, m_exp[33]});
      chk("rsp_zero", {31'd0, m_owner ? r1_rsp_zero : r0_rsp_zero}, {31'd0, m_exp[32]});
      chk("other_port_result", m_owner ? r0_rsp_result : r1_rsp_result, 32'd0);
    end
    if ((r0_rsp_valid && r0_rsp_ready) || (r1_rsp_valid && r1_rsp_ready)) n_rsp_seen++;
    hs = (v0 && r0_rsp_ready) || (v1 && r1_rsp_ready);
    @(posedge clk);
    #1;
    if (hs) begin
      m_busy = 1'b0;
      n_rsp_model++;
    end else if (m_busy) begin
      m_age++;
    end
    if (g0 || g1) begin
      m_busy  = 1'b1;
      m_age   = 0;
      m_owner = g1;
      m_last  = g1;
      m_exp   = g1 ? alu_f(r1_dataa, r1_datab, r1_ctr) : alu_f(r0_dataa, r0_datab, r0_ctr);
      if (g1) r1_valid = 1'b0;
      else    r0_valid = 1'b0;
    end
  endtask

  // Single operation on an idle arbiter with the response consumed at once.
  task automatic run_op(input bit n, input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] c, input logic [31:0] er, input bit el,
                        input bit ez, input string tag);
    if (n) begin r1_dataa = a; r1_datab = b; r1_ctr = c; r1_valid = 1'b1; end
    else   begin r0_dataa = a; r0_datab = b; r0_ctr = c; r0_valid = 1'b1; end
    #1;
    chk({tag, "_ready_same_cycle"}, {31'd0, n ? r1_ready : r0_ready}, 32'd1);
    tick();
    tick();
    chk({tag, "_rsp_valid"}, {31'd0, n ? r1_rsp_valid : r0_rsp_valid}, 32'd1);
    chk({tag, "_result"}, n ? r1_rsp_result : r0_rsp_result, er);
    chk({tag, "_less"}, {31'd0, n ? r1_rsp_less : r0_rsp_less}, {31'd0, el});
    chk({tag, "_zero"}, {31'd0, n ? r1_rsp_zero : r0_rsp_zero}, {31'd0, ez});
    tick();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // reset state
    #1;
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_rsp_valid", {30'd0, r1_rsp_valid, r0_rsp_valid}, 32'd0);
    chk("reset_alu_ctr", {28'd0, alu_ctr}, 32'd0);
    chk("reset_alu_dataa", alu_dataa, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // tie from reset: r0 first, then r1
    r0_dataa = 32'd7;  r0_datab = 32'd7;  r0_ctr = 4'b1000; r0_valid = 1'b1;
    r1_dataa = 32'hFF; r1_datab = 32'h0F; r1_ctr = 4'b0100; r1_valid = 1'b1;
    #1;
    chk("tie0_r0_ready", {31'd0, r0_ready}, 32'd1);
    chk("tie0_r1_ready", {31'd0, r1_ready}, 32'd0);
    tick();
    tick();
    chk("sub_zero", {31'd0, r0_rsp_zero}, 32'd1);
    chk("sub_result", r0_rsp_result, 32'd0);
    chk("sub_r1_rsp_valid", {31'd0, r1_rsp_valid}, 32'd0);
    tick();
    chk("r1_ready_after_r0", {31'd0, r1_ready}, 32'd1);
    tick();
    tick();
    chk("xor_result", r1_rsp_result, 32'h0000_00F0);
    tick();
    // next tie after r1 was served goes to r0
    r0_valid = 1'b1; r1_valid = 1'b1;
    #1;
    chk("tie1_r0_ready", {31'd0, r0_ready}, 32'd1);
    repeat (6) tick();
    // both of those served; r1 was last, so the next tie again favours r0, then r1
    r0_valid = 1'b1; r1_valid = 1'b1;
    tick();
    chk("tie2_r1_waits", {31'd0, r1_valid}, 32'd1);
    repeat (5) tick();

    // single-port operations
    run_op(1'b0, 32'd5, 32'd3, 4'b0000, 32'd8, 1'b0, 1'b0, "add");
    run_op(1'b1, 32'hFFFF_FFFF, 32'd1, 4'b0010, 32'd1, 1'b1, 1'b0, "slt");
    run_op(1'b1, 32'hFFFF_FFFF, 32'd1, 4'b0011, 32'd0, 1'b0, 1'b1, "sltu");
    run_op(1'b0, 32'h1234_5678, 32'd9, 4'b1111, 32'h1234_5678 ^ ~32'd9, 1'b0, 1'b0, "undef");

    // back-pressure on r0 while r1 waits
    r0_dataa = 32'h8000_0000; r0_datab = 32'd4; r0_ctr = 4'b1101; r0_valid = 1'b1;
    r0_rsp_ready = 1'b0;
    tick();
    r1_dataa = 32'd10; r1_datab = 32'd20; r1_ctr = 4'b0000; r1_valid = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("sra_held", r0_rsp_result, 32'hF800_0000);
      chk("sra_busy", {31'd0, busy}, 32'd1);
      chk("sra_r1_blocked", {31'd0, r1_ready}, 32'd0);
      tick();
    end
    r0_rsp_ready = 1'b1;
    tick();
    chk("r1_accept_after_hs", {31'd0, r1_ready}, 32'd1);
    repeat (3) tick();

    // reset during ISSUE
    r0_dataa = 32'h0000_00FF; r0_datab = 32'h0000_0F0F; r0_ctr = 4'b0111; r0_valid = 1'b1;
    tick();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_ready", {30'd0, r1_ready, r0_ready}, 32'd0);
    chk("rst_rsp_valid", {30'd0, r1_rsp_valid, r0_rsp_valid}, 32'd0);
    chk("rst_alu_ctr", {28'd0, alu_ctr}, 32'd0);
    chk("rst_alu_dataa", alu_dataa, 32'd0);
    chk("rst_rsp_result", r0_rsp_result, 32'd0);
    m_busy = 1'b0; m_last = 1'b1; m_owner = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) tick();
    r0_valid = 1'b1; r1_valid = 1'b1;
    #1;
    chk("post_rst_tie_r0", {31'd0, r0_ready}, 32'd1);
    chk("post_rst_tie_r1", {31'd0, r1_ready}, 32'd0);
    repeat (7) tick();

    // random traffic on both ports
    for (int i = 0; i < 400; i++) begin
      if (!r0_valid && ($urandom_range(0, 1) != 0)) begin
        r0_dataa = $urandom; r0_datab = $urandom; r0_ctr = 4'($urandom); r0_valid = 1'b1;
      end
      if (!r1_valid && ($urandom_range(0, 1) != 0)) begin
        r1_dataa = $urandom; r1_datab = $urandom; r1_ctr = 4'($urandom); r1_valid = 1'b1;
      end
      r0_rsp_ready = ($urandom_range(0, 3) != 0);
      r1_rsp_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    r0_rsp_ready = 1'b1; r1_rsp_ready = 1'b1;
    repeat (12) tick();
    chk("pending_r0_drained", {31'd0, r0_valid}, 32'd0);
    chk("pending_r1_drained", {31'd0, r1_valid}, 32'd0);
    chk("response_count", n_rsp_seen, n_rsp_model);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
